fetch_ctrl: RTL

Fetch-stage sequencer that owns the fetch PC and drives the instruction-memory request handshake. It handles decode-stage stalls via a 1-entry hold buffer and execute-stage misprediction redirects, including redirects that arrive while a memory request is outstanding. It delivers PCF, InstrF and ValidF to the F/D pipeline boundary.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
package fetch_pkg;

    // BOOT    : one idle cycle after reset before the first request
    // REQ     : request outstanding on the instruction-memory port
    // HOLD    : fetched word parked in the hold buffer while decode stalls
    // DISCARD : waiting out a request made stale by a redirect
    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential fetch increment; wraps naturally at 32 bits.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives the instruction-memory
// request handshake, buffers one word across decode stalls and handles
// execute-stage redirects, including redirects that race an outstanding request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// BOOT    | post-reset idle cycle, no request
// REQ     | IMemReq high at ReqAddr, waiting for IMemAck
// HOLD    | word captured while StallD=1, waiting for decode to accept
// DISCARD | redirected mid-request; drain the old ack, then refetch
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD  = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        MissPredictionE,
    input  logic [31:0] BranchTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic        ValidF,
    output logic        FlushD,
    output logic        FlushE
);

    fetch_state_t state, state_nxt;

    logic [31:0] fetch_pc,   fetch_pc_nxt;
    logic [31:0] req_addr,   req_addr_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] hold_pc,    hold_pc_nxt;
    logic        hold_valid, hold_valid_nxt;
    logic [31:0] pcf_q,      pcf_nxt;
    logic [31:0] instr_q,    instr_nxt;
    logic        valid_q,    valid_nxt;

    // Register update; synchronous reset returns to BOOT with an empty pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            req_addr   <= RESET_PC;
            hold_instr <= NOP_WORD;
            hold_pc    <= RESET_PC;
            hold_valid <= 1'b0;
            pcf_q      <= RESET_PC;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            req_addr   <= req_addr_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_valid <= hold_valid_nxt;
            pcf_q      <= pcf_nxt;
            instr_q    <= instr_nxt;
            valid_q    <= valid_nxt;
        end
    end

    // Next-state and datapath selection; a redirect outranks stall and ack.
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        req_addr_nxt   = req_addr;
        hold_instr_nxt = hold_instr;
        hold_pc_nxt    = hold_pc;
        hold_valid_nxt = hold_valid;
        pcf_nxt        = pcf_q;
        instr_nxt      = instr_q;
        valid_nxt      = valid_q;

        if (MissPredictionE) begin
            fetch_pc_nxt   = BranchTargetE;
            valid_nxt      = 1'b0;
            instr_nxt      = NOP_WORD;
            hold_valid_nxt = 1'b0;
            unique case (state)
                REQ: begin
                    // An ack in the same cycle retires the old request, so the
                    // target can be issued immediately; otherwise drain it first.
                    if (IMemAck) begin
                        req_addr_nxt = BranchTargetE;
                        state_nxt    = REQ;
                    end else begin
                        state_nxt    = DISCARD;
                    end
                end
                BOOT, HOLD: begin
                    req_addr_nxt = BranchTargetE;
                    state_nxt    = REQ;
                end
                DISCARD: begin
                    // The in-flight address must stay put; only the landing
                    // point moves to the newest target.
                    state_nxt = DISCARD;
                end
                default: state_nxt = BOOT;
            endcase
        end else begin
            unique case (state)
                BOOT: begin
                    req_addr_nxt = fetch_pc;
                    state_nxt    = REQ;
                end
                REQ: begin
                    if (IMemAck) begin
                        fetch_pc_nxt = pc_plus4(req_addr);
                        if (!StallD) begin
                            instr_nxt    = IMemData;
                            pcf_nxt      = req_addr;
                            valid_nxt    = 1'b1;
                            req_addr_nxt = pc_plus4(req_addr);
                        end else begin
                            hold_instr_nxt = IMemData;
                            hold_pc_nxt    = req_addr;
                            hold_valid_nxt = 1'b1;
                            state_nxt      = HOLD;
                        end
                    end else if (!StallD) begin
                        valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!StallD) begin
                        instr_nxt      = hold_instr;
                        pcf_nxt        = hold_pc;
                        valid_nxt      = hold_valid;
                        hold_valid_nxt = 1'b0;
                        req_addr_nxt   = fetch_pc;
                        state_nxt      = REQ;
                    end
                end
                DISCARD: begin
                    valid_nxt = 1'b0;
                    if (IMemAck) begin
                        req_addr_nxt = fetch_pc;
                        state_nxt    = REQ;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // Memory port and pipeline-boundary outputs; reset masks the request and flushes.
    always_comb begin
        IMemReq  = !rst && ((state == REQ) || (state == DISCARD));
        IMemAddr = req_addr;
        PCF      = pcf_q;
        InstrF   = instr_q;
        ValidF   = valid_q;
        FlushD   = MissPredictionE && !rst;
        FlushE   = MissPredictionE && !rst;
    end

endmodule
